// File: rtl/mem_pkg.sv
// Shared types and constants for the AS6C1008 two-port arbiter/sequencer.
//   - state_e      : sequencer states (idle, address setup, strobe, done/hold)
//   - ADDR_W       : requester address width
//   - DATA_W       : RAM data width
//   - MEM_ADDR_W   : RAM address pin count
//   - *_CYCLES_DEF : default strobe lengths in clock cycles
//   - strobe_load  : strobe counter load value for a transaction type
package mem_pkg;

  localparam int unsigned ADDR_W        = 7;
  localparam int unsigned DATA_W        = 8;
  localparam int unsigned MEM_ADDR_W    = 17;
  localparam int unsigned CNT_W         = 3;
  localparam int unsigned WR_CYCLES_DEF = 4;
  localparam int unsigned RD_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStrobe,
    StDone
  } state_e;

  // The counter counts down to zero, so an N-cycle strobe loads N-1.
  function automatic logic [CNT_W-1:0] strobe_load(input logic        is_write,
                                                   input int unsigned wr_cycles,
                                                   input int unsigned rd_cycles);
    return is_write ? CNT_W'(wr_cycles - 1) : CNT_W'(rd_cycles - 1);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic.
//   clk_i, reset_ni : clock, asynchronous active-low reset
//   req_i[1:0]      : request per port
//   advance_i       : grant is being taken this cycle; move the priority pointer
//   grant_o[1:0]    : one-hot grant, or zero when nobody requests
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  // ptr_q names the port that wins a tie.
  logic ptr_q, ptr_d;

  always_comb begin
    grant_o = 2'b00;
    unique case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  // After a grant the tie goes to the port that was not just served.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && (grant_o != 2'b00)) begin
      ptr_d = grant_o[0];
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter and cycle sequencer for the AS6C1008 SRAM.
// Port 0 is the host bus, port 1 the auxiliary engine; round-robin on ties.
//   clk_i, reset_ni        : clock, asynchronous active-low reset
//   reqN_i, weN_i          : request and write(1)/read(0), held until ackN_o
//   addrN_i, wdataN_i      : address and write data, held until ackN_o
//   ackN_o                 : one-cycle completion pulse
//   rdata_o                : last read data, shared by both ports
//   busy_o                 : sequencer not idle
//   mem_address_o          : RAM address (upper bits tied low)
//   mem_data_io            : RAM data pins, driven only for writes
//   ceh_no/ce2_o           : RAM chip enables
//   we_no/oe_no            : RAM write / output enables
// Sequence: IDLE -> SETUP (1) -> STROBE (WR_CYCLES or RD_CYCLES) -> DONE (1).
// WR_CYCLES and RD_CYCLES must lie in 1..7.
module mem_arbiter import mem_pkg::*; #(
  parameter int unsigned WR_CYCLES = WR_CYCLES_DEF,
  parameter int unsigned RD_CYCLES = RD_CYCLES_DEF
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  req0_i,
  input  logic                  req1_i,
  input  logic                  we0_i,
  input  logic                  we1_i,
  input  logic [ADDR_W-1:0]     addr0_i,
  input  logic [ADDR_W-1:0]     addr1_i,
  input  logic [DATA_W-1:0]     wdata0_i,
  input  logic [DATA_W-1:0]     wdata1_i,
  output logic                  ack0_o,
  output logic                  ack1_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  busy_o,
  output logic [MEM_ADDR_W-1:0] mem_address_o,
  inout  wire  [DATA_W-1:0]     mem_data_io,
  output logic                  ceh_no,
  output logic                  ce2_o,
  output logic                  we_no,
  output logic                  oe_no
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic                port_q, port_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          grant;
  logic                drive_data;

  rr_arbiter2 u_rr_arbiter2 (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .req_i     ({req1_i, req0_i}),
    .advance_i (state_q == StIdle),
    .grant_o   (grant)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    port_d  = port_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (grant != 2'b00) begin
          state_d = StSetup;
          port_d  = grant[1];
          we_d    = grant[1] ? we1_i    : we0_i;
          addr_d  = grant[1] ? addr1_i  : addr0_i;
          wdata_d = grant[1] ? wdata1_i : wdata0_i;
        end
      end
      StSetup: begin
        state_d = StStrobe;
        cnt_d   = strobe_load(we_q, WR_CYCLES, RD_CYCLES);
      end
      StStrobe: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          // Capture on the edge that ends the output-enable strobe.
          if (!we_q) begin
            rdata_d = mem_data_io;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      port_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      port_q  <= port_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Pins decode from the registered state only, so reset clears them at once.
  always_comb begin
    ceh_no = !((state_q == StSetup) || (state_q == StStrobe));
    ce2_o  = (state_q == StSetup) || (state_q == StStrobe);
    we_no  = !((state_q == StStrobe) && we_q);
    oe_no  = !((state_q == StStrobe) && !we_q);
    ack0_o = (state_q == StDone) && !port_q;
    ack1_o = (state_q == StDone) && port_q;
    busy_o = (state_q != StIdle);
    // Write data stays on the bus through DONE to cover the RAM hold time.
    drive_data = we_q && (state_q != StIdle);
  end

  assign rdata_o       = rdata_q;
  assign mem_address_o = {{(MEM_ADDR_W - ADDR_W){1'b0}}, addr_q};
  assign mem_data_io   = drive_data ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int WrA = 4;
  localparam int RdA = 2;
  localparam int WrB = 1;
  localparam int RdB = 7;
  // Value seen on a bus nobody drives (pull-ups); writes never use it.
  localparam logic [7:0] BusFloat = 8'hFF;

  typedef struct packed {
    logic       w;
    logic [6:0] a;
    logic [7:0] d;
  } op_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT A: default strobe lengths
  logic        req0, req1, we0, we1;
  logic [6:0]  addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        ack0, ack1, busy, ceh_n, ce2, we_n, oe_n;
  logic [7:0]  rdata;
  logic [16:0] mem_addr;
  tri   [7:0]  bus_a;

  // DUT B: WR_CYCLES=1, RD_CYCLES=7, port 1 unused
  logic        b_req0, b_we0;
  logic [6:0]  b_addr0;
  logic [7:0]  b_wdata0;
  logic        b_ack0, b_ack1, b_busy, b_ceh_n, b_ce2, b_we_n, b_oe_n;
  logic [7:0]  b_rdata;
  logic [16:0] b_mem_addr;
  tri   [7:0]  bus_b;

  for (genvar g = 0; g < 8; g++) begin : g_pull
    pullup pu_a (bus_a[g]);
    pullup pu_b (bus_b[g]);
  end

  mem_arbiter u_dut_a (
    .clk_i(clk), .reset_ni(rst_n),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .ack0_o(ack0), .ack1_o(ack1), .rdata_o(rdata), .busy_o(busy),
    .mem_address_o(mem_addr), .mem_data_io(bus_a),
    .ceh_no(ceh_n), .ce2_o(ce2), .we_no(we_n), .oe_no(oe_n)
  );

  mem_arbiter #(.WR_CYCLES(WrB), .RD_CYCLES(RdB)) u_dut_b (
    .clk_i(clk), .reset_ni(rst_n),
    .req0_i(b_req0), .req1_i(1'b0), .we0_i(b_we0), .we1_i(1'b0),
    .addr0_i(b_addr0), .addr1_i(7'd0), .wdata0_i(b_wdata0), .wdata1_i(8'd0),
    .ack0_o(b_ack0), .ack1_o(b_ack1), .rdata_o(b_rdata), .busy_o(b_busy),
    .mem_address_o(b_mem_addr), .mem_data_io(bus_b),
    .ceh_no(b_ceh_n), .ce2_o(b_ce2), .we_no(b_we_n), .oe_no(b_oe_n)
  );

  // SRAM models: drive on output enable, store on each write-enabled edge.
  logic [7:0] ram_a [128] = '{default: 8'h00};
  logic [7:0] ram_b [128] = '{default: 8'h00};
  assign bus_a = (!ceh_n && ce2 && !oe_n && we_n) ? ram_a[mem_addr[6:0]] : 8'hzz;
  assign bus_b = (!b_ceh_n && b_ce2 && !b_oe_n && b_we_n) ? ram_b[b_mem_addr[6:0]] : 8'hzz;
  always @(posedge clk) begin
    if (!ceh_n && ce2 && !we_n) ram_a[mem_addr[6:0]] <= bus_a;
    if (!b_ceh_n && b_ce2 && !b_we_n) ram_b[b_mem_addr[6:0]] <= bus_b;
  end

  // Reference state
  logic [7:0] ref_mem [128] = '{default: 8'h00};
  logic [7:0] last_rd;
  int         m_ptr;
  op_t        q0[$], q1[$];
  int         ack_port_q[$], ack_cyc_q[$], samp_cyc_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.w = 1'($urandom_range(1, 0));
    o.a = 7'($urandom_range(15, 0));
    o.d = 8'($urandom_range(254, 0));
    return o;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; b_req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    last_rd = 8'h00;
  endtask

  // Serves q0/q1 as two requesters; after each ack a port idles 0..gap_max
  // cycles (0 keeps req high). The model grants at the first idle cycle,
  // predicts ack N+2 cycles after the sampling cycle, and tracks RAM contents.
  task automatic run_ops(input int budget, input int gap_max);
    int         c = 0;
    int         idle_at = 0;
    int         ack_at = -1;
    bit         inflight = 1'b0;
    int         cur_p = 0;
    op_t        cur = '0;
    int         wait_n [2] = '{0, 0};
    int         wl = 0, ol = 0, cl = 0, bad = 0, n = 0;
    logic [1:0] exp_ack;
    ack_port_q.delete(); ack_cyc_q.delete(); samp_cyc_q.delete();
    while ((q0.size() > 0 || q1.size() > 0 || inflight) && c < budget) begin
      @(negedge clk);
      exp_ack = (inflight && c == ack_at) ? ((cur_p == 1) ? 2'b10 : 2'b01) : 2'b00;
      chk("ack_pins", {ack1, ack0}, exp_ack);
      if (ack0 || ack1) begin
        ack_port_q.push_back(ack1 ? 1 : 0);
        ack_cyc_q.push_back(c);
      end
      if (!we_n && !oe_n) bad++;
      if ((!we_n || !oe_n) && ceh_n) bad++;
      if (ceh_n === ce2) bad++;
      if (busy !== inflight) bad++;
      if (!inflight && bus_a !== BusFloat) bad++;
      if (inflight) begin
        if (mem_addr !== {10'd0, cur.a}) bad++;
        if (cur.w && bus_a !== cur.d) bad++;
        if (!cur.w && oe_n && bus_a !== BusFloat) bad++;
      end
      if (!(exp_ack != 2'b00 && !cur.w) && rdata !== last_rd) bad++;
      if (!we_n) wl++;
      if (!oe_n) ol++;
      if (!ceh_n) cl++;
      if (exp_ack != 2'b00) begin
        n = cur.w ? WrA : RdA;
        chk("we_low_len", wl, cur.w ? WrA : 0);
        chk("oe_low_len", ol, cur.w ? 0 : RdA);
        chk("ce_len", cl, n + 1);
        if (!cur.w) begin
          chk("rdata", rdata, ref_mem[cur.a]);
          last_rd = ref_mem[cur.a];
        end
        if (cur_p == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
        wait_n[cur_p] = int'($urandom_range(gap_max, 0));
        inflight = 1'b0;
      end
      if (q0.size() > 0 && wait_n[0] == 0) begin
        req0 = 1'b1; we0 = q0[0].w; addr0 = q0[0].a; wdata0 = q0[0].d;
      end else begin
        req0 = 1'b0; we0 = 1'($urandom); addr0 = 7'($urandom); wdata0 = 8'($urandom);
        if (wait_n[0] > 0) wait_n[0]--;
      end
      if (q1.size() > 0 && wait_n[1] == 0) begin
        req1 = 1'b1; we1 = q1[0].w; addr1 = q1[0].a; wdata1 = q1[0].d;
      end else begin
        req1 = 1'b0; we1 = 1'($urandom); addr1 = 7'($urandom); wdata1 = 8'($urandom);
        if (wait_n[1] > 0) wait_n[1]--;
      end
      if (!inflight && c >= idle_at && (req0 || req1)) begin
        cur_p = (req0 && req1) ? m_ptr : (req1 ? 1 : 0);
        cur = (cur_p == 1) ? q1[0] : q0[0];
        m_ptr = 1 - cur_p;
        inflight = 1'b1;
        n = cur.w ? WrA : RdA;
        ack_at = c + n + 2;
        idle_at = c + n + 3;
        samp_cyc_q.push_back(c);
        if (cur.w) ref_mem[cur.a] = cur.d;
        wl = 0; ol = 0; cl = 0;
      end
      c++;
    end
    chk("ops_drained", q0.size() + q1.size() + int'(inflight), 0);
    chk("protocol", bad, 0);
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic b_txn(input logic w, input logic [6:0] a, input logic [7:0] d,
                       output int lat, output int wl, output int ol);
    bit got = 1'b0;
    @(negedge clk);
    b_req0 = 1'b1; b_we0 = w; b_addr0 = a; b_wdata0 = d;
    lat = 0; wl = 0; ol = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (!b_we_n) wl++;
      if (!b_oe_n) ol++;
      if (b_ack0) got = 1'b1;
    end
    b_req0 = 1'b0;
    chk("b_ack_seen", got, 1);
  endtask

  initial begin
    int n, acks, lat, wl, ol;
    rst_n = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    b_req0 = 0; b_we0 = 0; b_addr0 = 0; b_wdata0 = 0;
    m_ptr = 0;
    last_rd = 8'h00;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_ceh_n", ceh_n, 1);
    chk("rst_ce2", ce2, 0);
    chk("rst_we_n", we_n, 1);
    chk("rst_oe_n", oe_n, 1);
    chk("rst_addr", mem_addr, 0);
    chk("rst_acks", {ack1, ack0}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bus", bus_a, BusFloat);
    @(negedge clk);
    rst_n = 1'b1;

    // Write A5 to 05 on port 0, then read it back.
    q0.push_back('{w: 1'b1, a: 7'h05, d: 8'hA5});
    run_ops(50, 0);
    chk("t1_wr_acks", ack_cyc_q.size(), 1);
    if (ack_cyc_q.size() == 1) chk("t1_wr_latency", ack_cyc_q[0] - samp_cyc_q[0], 6);
    chk("t1_ram_05", ram_a[5], 8'hA5);
    q0.push_back('{w: 1'b0, a: 7'h05, d: 8'h00});
    run_ops(50, 0);
    chk("t1_rd_acks", ack_cyc_q.size(), 1);
    if (ack_cyc_q.size() == 1) chk("t1_rd_latency", ack_cyc_q[0] - samp_cyc_q[0], 4);
    chk("t1_rdata", rdata, 8'hA5);

    // Both ports held from reset: port 0 first, then strict alternation.
    do_reset();
    q0.push_back('{w: 1'b1, a: 7'h10, d: 8'h3C});
    q1.push_back('{w: 1'b1, a: 7'h11, d: 8'hC3});
    q0.push_back('{w: 1'b0, a: 7'h11, d: 8'h00});
    q1.push_back('{w: 1'b0, a: 7'h10, d: 8'h00});
    run_ops(100, 0);
    chk("t2_acks", ack_port_q.size(), 4);
    for (int i = 0; i < ack_port_q.size() && i < 4; i++) chk("t2_order", ack_port_q[i], i % 2);

    // Lone requester on port 1, three held reads.
    for (int i = 0; i < 3; i++) q1.push_back('{w: 1'b0, a: 7'(16 + i), d: 8'h00});
    run_ops(100, 0);
    chk("t3_acks", ack_port_q.size(), 3);
    for (int i = 0; i < ack_port_q.size(); i++) chk("t3_port", ack_port_q[i], 1);
    for (int i = 0; i + 1 < ack_cyc_q.size(); i++)
      chk("t3_spacing", ack_cyc_q[i + 1] - ack_cyc_q[i], 5);

    // Random mix on both ports with random idle gaps.
    for (int i = 0; i < 30; i++) begin
      q0.push_back(rand_op());
      q1.push_back(rand_op());
    end
    run_ops(2000, 2);
    chk("t4_acks", ack_port_q.size(), 60);

    // Reset during the second write-strobe cycle.
    do_reset();
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 7'h22; wdata0 = 8'h3C;
    n = 0;
    while (we_n !== 1'b0 && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("t5_we_low_1st", we_n, 0);
    @(negedge clk);
    chk("t5_we_low_2nd", we_n, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_we_n", we_n, 1);
    chk("t5_oe_n", oe_n, 1);
    chk("t5_ceh_n", ceh_n, 1);
    chk("t5_ce2", ce2, 0);
    chk("t5_bus", bus_a, BusFloat);
    chk("t5_busy", busy, 0);
    chk("t5_ack0", ack0, 0);
    req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    last_rd = 8'h00;
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack0 || ack1) acks++;
    end
    chk("t5_no_ack", acks, 0);
    chk("t5_idle", busy, 0);

    // Strobe-length sweep on DUT B.
    b_txn(1'b1, 7'h33, 8'h5A, lat, wl, ol);
    chk("t6_wr_latency", lat, 3);
    chk("t6_we_len", wl, 1);
    chk("t6_wr_oe_len", ol, 0);
    chk("t6_ram_33", ram_b[7'h33], 8'h5A);
    b_txn(1'b0, 7'h33, 8'h00, lat, wl, ol);
    chk("t6_rd_latency", lat, 9);
    chk("t6_oe_len", ol, 7);
    chk("t6_rd_we_len", wl, 0);
    chk("t6_rdata", b_rdata, 8'h5A);
    chk("t6_ack1", b_ack1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and cycle sequencer for the Alliance AS6C1008 SRAM. Grants the RAM to one of two requesters (port 0: host bus interface, port 1: auxiliary engine) using round-robin priority. Generates clock-aligned chip-select, write-enable and output-enable sequences with programmable strobe lengths. Sits between the requesters and the RAM pins, replacing edge-triggered strobe generation with a single-clock FSM.

## Interface
Parameters:
- WR_CYCLES, 4, cycles we_n is held low (legal 1..7)
- RD_CYCLES, 2, cycles oe_n is held low before data capture (legal 1..7)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req0, req1  in  1  request from port 0 / port 1
- we0, we1  in  1  1 = write, 0 = read; qualified by reqN
- addr0, addr1  in  7  RAM address
- wdata0, wdata1  in  8  write data
- ack0, ack1  out  1  one-cycle completion pulse
- rdata  out  8  registered read data, shared by both ports
- busy  out  1  high whenever state is not IDLE
- mem_address  out  17  RAM address; bits 16:7 tied 0
- mem_data  inout  8  RAM data pins
- ceh_n, ce2  out  1  RAM chip enables (active low / active high)
- we_n, oe_n  out  1  RAM write / output enable, active low

## Operation
- FSM states: IDLE, SETUP, STROBE, DONE.
- IDLE: if any reqN is high, latch the winner's we, addr and wdata; go to SETUP. Otherwise stay.
- Arbitration:
  - A single requester always wins.
  - If both request, the port indicated by the priority pointer wins.
  - Pointer moves to the other port after every grant.
  - Reset value of the pointer: port 0.
- SETUP (1 cycle): mem_address = latched address; ceh_n=0, ce2=1; for a write, mem_data is driven with the latched wdata.
- STROBE (N cycles; N = WR_CYCLES for writes, RD_CYCLES for reads): we_n=0 or oe_n=0. A 3-bit counter loads N-1 and counts down to 0.
- DONE (1 cycle):
  - Strobes return high; ceh_n=1, ce2=0.
  - The winning ackN is high.
  - For a write, address and data stay driven for hold time.
  - For a read, rdata was captured from mem_data on the clock edge that leaves STROBE.
  - Next state is IDLE.
- Requester contract:
  - Hold reqN, weN, addrN and wdataN stable until ackN.
  - Drop reqN in the cycle after ackN, or keep it high to request a new transaction; a held request re-enters arbitration in IDLE.
- mem_data is hi-Z in IDLE, during every read, and in reset.
- rdata holds its value until the next read completes.
- Requests that arrive while busy wait; they are never dropped or queued beyond the level-sensitive reqN.

## Timing
- Reset values: ceh_n=1, ce2=0, we_n=1, oe_n=1, mem_address=0, ack0=ack1=0, rdata=0, busy=0, mem_data hi-Z, state IDLE.
- A request sampled in IDLE at edge k gives:
  - SETUP during cycle k+1
  - STROBE during cycles k+2 .. k+1+N
  - DONE (ack) during cycle k+2+N
- Write latency with defaults: 6 cycles from the sampling edge to ack; read latency: 4 cycles.
- Minimum request-to-request period per transaction is N+3 cycles, because IDLE is always visited once.
- we_n and oe_n are never low in the same cycle. Neither is low outside STROBE.
- Asynchronous reset mid-transaction:
  - All strobes and enables deassert immediately and mem_data goes hi-Z.
  - No ack is issued and the transaction is lost.
- Address lines change only on the IDLE→SETUP edge.

## Structure
- Package mem_pkg holds:
  - the state enum (IDLE, SETUP, STROBE, DONE)
  - widths ADDR_W=7, DATA_W=8, MEM_ADDR_W=17
  - default strobe-length constants
- Sub-module rr_arbiter2: 2-way round-robin grant logic with pointer register. Inputs req[1:0], advance; output grant[1:0] (one-hot or zero).
- The top level contains the FSM, strobe counter, latch registers and the tri-state driver.

## Test plan
- Write then read, port 0: req0, we0=1, addr0=7'h05, wdata0=8'hA5. Required: ack0 at cycle 6, we_n low exactly 4 cycles, RAM model holds A5. Then read 7'h05: ack0 at cycle 4, rdata=8'hA5, mem_data never driven by the block during the read.
- Simultaneous requests after reset: req0 write 7'h10, req1 write 7'h11, both asserted together and held. Required: port 0 served first, then port 1. With both held continuously: grants alternate 0,1,0,1.
- Lone requester: req1 only, 3 back-to-back reads with req1 held. Required: three ack1 pulses spaced 5 cycles apart; ack0 never asserted.
- Reset mid-write: assert reset_n=0 during the second we_n-low cycle. Required: we_n=1, ceh_n=1, ce2=0 and mem_data hi-Z in the same cycle; no ack; busy=0.
- Parameter sweep: WR_CYCLES=1, RD_CYCLES=7. Required: we_n low 1 cycle, oe_n low 7 cycles; ack latencies 3 and 9.
